// File: rtl/pwm_capture_if.sv
// Signal bundle for pwm_capture: capture controls in, measurement results out.
// The slave side is the capture block; the master side is whatever configures and reads it.
interface pwm_capture_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             en;
  logic             pwm_in;
  logic [3:0]       div;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;
  logic             level;

  modport master (
    output en, pwm_in, div,
    input  period, high_time, valid, timeout, level
  );

  modport slave (
    input  en, pwm_in, div,
    output period, high_time, valid, timeout, level
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with a power-of-two prescaler, saturating counters
// and a timeout when no edge arrives for a full counter range.
module pwm_capture #(
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  pwm_capture_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  localparam logic [CNT_W-1:0] TickMax = '1;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, hist_q;
  logic [3:0]       div_q, div_d;
  logic [14:0]      pre_q, pre_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic             rise, fall;
  logic [14:0]      pre_base;
  logic [15:0]      pre_inc;
  logic [CNT_W-1:0] tick_base;

  assign rise = sync2_q & ~hist_q;
  assign fall = ~sync2_q & hist_q;

  always_comb begin
    // A rise restarts the interval and counts its own cycle as the first one.
    pre_base  = rise ? '0 : pre_q;
    tick_base = rise ? '0 : tick_q;
    div_d     = rise ? bus_io.div : div_q;
    pre_inc   = {1'b0, pre_base} + 16'd1;
    if (pre_inc == (16'd1 << div_d)) begin
      pre_d  = '0;
      tick_d = (tick_base == TickMax) ? tick_base : tick_base + CNT_W'(1);
    end else begin
      pre_d  = pre_inc[14:0];
      tick_d = tick_base;
    end

    state_d   = state_q;
    shadow_d  = shadow_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (!bus_io.en) begin
      state_d   = StIdle;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            state_d   = StHigh;
            timeout_d = 1'b0;
          end
        end
        StHigh: begin
          if (tick_q == TickMax) begin
            state_d   = StIdle;
            timeout_d = 1'b1;
          end else if (fall) begin
            shadow_d = tick_q;
            state_d  = StLow;
          end
        end
        StLow: begin
          if (tick_q == TickMax) begin
            state_d   = StIdle;
            timeout_d = 1'b1;
          end else if (rise) begin
            period_d = tick_q;
            high_d   = shadow_q;
            valid_d  = 1'b1;
            state_d  = StHigh;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      hist_q    <= 1'b0;
      div_q     <= '0;
      pre_q     <= '0;
      tick_q    <= '0;
      shadow_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= bus_io.pwm_in;
      sync2_q   <= sync1_q;
      hist_q    <= sync2_q;
      div_q     <= div_d;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      shadow_q  <= shadow_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus_io.period    = period_q;
  assign bus_io.high_time = high_q;
  assign bus_io.valid     = valid_q;
  assign bus_io.timeout   = timeout_q;
  assign bus_io.level     = sync2_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus pushes expected captures, the monitor
// pops them on every valid pulse and also checks the arrival cycle.
module tb_pwm_capture;

  localparam int unsigned W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pwm_capture_if #(.CNT_W(W)) bus_if ();

  pwm_capture #(.CNT_W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus_if)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned per;
    int unsigned hi;
    int unsigned at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Model: 0 idle, 1 high, 2 low
  int          m_state    = 0;
  int unsigned m_rise_cyc = 0;
  int unsigned m_hi       = 0;
  int unsigned m_div      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rise_edge();
    if (m_state == 2 && bus_if.en) begin
      sb.push_back('{per: (cyc - m_rise_cyc) >> m_div, hi: m_hi >> m_div, at: cyc + 3});
    end
    if (bus_if.en) m_state = 1;
    m_rise_cyc    = cyc;
    m_div         = bus_if.div;
    bus_if.pwm_in = 1'b1;
  endtask

  task automatic fall_edge();
    if (m_state == 1) begin
      m_hi    = cyc - m_rise_cyc;
      m_state = 2;
    end
    bus_if.pwm_in = 1'b0;
  endtask

  task automatic pwm_period(input int hi, input int lo);
    rise_edge();
    hold(hi);
    fall_edge();
    hold(lo);
  endtask

  task automatic set_en(input logic v);
    bus_if.en = v;
    if (!v) m_state = 0;
  endtask

  task automatic set_div(input logic [3:0] d);
    set_en(1'b0);
    hold(5);
    bus_if.div = d;
    set_en(1'b1);
    hold(5);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_period"}, bus_if.period, 0);
    check_eq({tag, "_high"}, bus_if.high_time, 0);
    check_eq({tag, "_valid"}, bus_if.valid, 0);
    check_eq({tag, "_timeout"}, bus_if.timeout, 0);
    check_eq({tag, "_level"}, bus_if.level, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus_if.valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("spurious_valid", bus_if.valid, 0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("period", bus_if.period, mon_e.per);
        check_eq("high_time", bus_if.high_time, mon_e.hi);
        check_eq("valid_cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    int unsigned c0;
    bus_if.en     = 1'b1;
    bus_if.pwm_in = 1'b0;
    bus_if.div    = 4'd0;
    hold(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    hold(4);

    // div=0, 100/25 waveform, then 1-clk pulses at 10-clk spacing
    repeat (4) pwm_period(25, 75);
    repeat (4) pwm_period(1, 9);

    // Prescaled values must floor
    set_div(4'd1);
    repeat (3) pwm_period(25, 76);
    set_div(4'd3);
    repeat (3) pwm_period(11, 26);
    set_div(4'd2);
    repeat (3) pwm_period(100, 300);
    set_div(4'd0);

    // Constant high for 300 clk: timeout at tick 255, no valid
    rise_edge();
    c0 = cyc;
    hold(257);
    check_eq("timeout_before_sat", bus_if.timeout, 0);
    hold(1);
    check_eq("timeout_at_sat", bus_if.timeout, 1);
    check_eq("timeout_cycle", cyc - c0, 258);
    hold(42);
    check_eq("timeout_held", bus_if.timeout, 1);
    check_eq("timeout_level", bus_if.level, 1);
    m_state = 0;
    fall_edge();
    hold(50);
    check_eq("timeout_level_low", bus_if.level, 0);
    rise_edge();
    hold(5);
    check_eq("timeout_cleared", bus_if.timeout, 0);
    hold(20);
    fall_edge();
    hold(75);
    rise_edge();
    hold(25);
    fall_edge();
    hold(40);

    // Asynchronous reset mid-LOW
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    hold(3);
    rst_n   = 1'b1;
    m_state = 0;
    hold(5);
    repeat (3) pwm_period(25, 75);

    // en dropped for 50 clk mid-period
    rise_edge();
    hold(10);
    set_en(1'b0);
    hold(15);
    fall_edge();
    hold(20);
    check_eq("en_off_period", bus_if.period, 100);
    check_eq("en_off_high", bus_if.high_time, 25);
    hold(15);
    set_en(1'b1);
    hold(1);
    check_eq("en_on_period", bus_if.period, 100);
    check_eq("en_on_high", bus_if.high_time, 25);
    check_eq("en_on_timeout", bus_if.timeout, 0);
    hold(40);
    repeat (3) pwm_period(30, 70);

    hold(10);
    check_eq("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 16: width of the measurement counters and result outputs.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  capture enable; level-sensitive.
REQ-005 pwm_in  input  1  external PWM signal, asynchronous to clk.
REQ-006 div  input  4  prescaler exponent; one count tick every 2^div clk cycles.
REQ-007 period  output  CNT_W  last measured rising-to-rising interval, in ticks.
REQ-008 high_time  output  CNT_W  last measured rising-to-falling interval, in ticks.
REQ-009 valid  output  1  one-cycle pulse when period/high_time update.
REQ-010 timeout  output  1  level; no edge seen within 2^CNT_W-1 ticks.
REQ-011 level  output  1  synchronized pwm_in level, meaningful while timeout=1.

Function
REQ-012 pwm_in SHALL pass through a 2-flop synchronizer plus one history flop; rise event = sync=1 & hist=0, fall event = sync=0 & hist=1.
REQ-013 Output latency SHALL be fixed: valid is high in the cycle after the 3rd rising clk edge at which pwm_in is sampled high (edge 1 = first high sample).
REQ-014 FSM states: IDLE, HIGH, LOW.
REQ-015 IDLE: wait for rise event -> HIGH; no valid generated.
REQ-016 HIGH: on fall event, latch high count into a shadow register -> LOW.
REQ-017 LOW: on rise event, load period <= period count and high_time <= shadow, pulse valid for 1 cycle -> HIGH.
REQ-018 Each rise event SHALL restart the period count, the high count and the prescaler; the edge cycle counts as the first cycle of the new interval.
REQ-019 Measured values SHALL equal floor(N / 2^div), where N is the clk-cycle count between the qualifying sync edges.
REQ-020 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 On saturation of the period count in any non-IDLE state: timeout <= 1, FSM -> IDLE, and period/high_time hold their last values.
REQ-022 timeout SHALL clear on the next rise event.
REQ-023 level SHALL equal the synchronizer output at all times.
REQ-024 en=0 SHALL force the FSM to IDLE, hold valid at 0, clear timeout, and hold period/high_time.
REQ-025 After en goes 0->1, the first valid requires two rise events.
REQ-026 A div change SHALL take effect at the next rise event; the in-flight measurement is undefined but bounded by saturation.
REQ-027 A rise and a fall in consecutive cycles (1-cycle-wide pulse) SHALL be captured with high_time = floor(1 / 2^div).
REQ-028 A constant-high or constant-low input SHALL produce no valid; only timeout.

Reset
REQ-029 While rst_n=0: FSM=IDLE, all sync/history flops=0, counters=0, period=0, high_time=0, valid=0, timeout=0, level=0.
REQ-030 After rst_n deasserts, operation starts on the first clk edge; a reset mid-measurement discards that measurement and produces no valid.

Verification
REQ-031 div=0, en=1, pwm_in period 100 clk, high 25 clk -> from the 2nd rise on, one valid per period with period=100, high_time=25.
REQ-032 div=2, period 400 clk, high 100 clk -> period=100, high_time=25; valid exactly once per 400 clk.
REQ-033 CNT_W=8, div=0, pwm_in held high for 300 clk after a rise -> timeout=1 at tick 255, level=1, no valid, FSM IDLE; the next full period clears timeout and yields a correct valid.
REQ-034 Rise at clk edge k -> valid high in the cycle after edge k+2 (latency check); 1-clk-wide high pulses at 10-clk spacing -> high_time=1, period=10.
REQ-035 rst_n pulsed low mid-LOW state -> all outputs 0 immediately (asynchronous); the first valid appears only after two subsequent rise events.
REQ-036 en dropped for 50 clk mid-period -> valid=0 and outputs held throughout; after re-enable, the first valid follows the 2nd rise with correct values.
